// File: rtl/ps2_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 transmit types, constants and frame builder.
// Revision : 1.0 - initial release
// =============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } ps2_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // Bit 0 is sent first: start(0), data LSB..MSB, odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : ps2_tx_fifo
// Brief    : Synchronous ready/valid FIFO with extended-pointer full/empty.
// Revision : 1.0 - initial release
// =============================================================================
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Same index with differing wrap bit means the writer is a full lap ahead.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;
    assign out_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// =============================================================================
// Module   : ps2_kbd_tx
// Brief    : PS/2 keyboard-side transmitter: queues scan codes and emits frames.
//            Define PS2_TX_BREAK_EN to add the brk input (0xF0 prefix frame).
// Revision : 1.0 - initial release
// =============================================================================
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef PS2_TX_BREAK_EN
    input  logic       brk,
`endif
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       overflow
);

`ifdef PS2_TX_BREAK_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam int CNT_MAX = (2*CLK_DIV > GAP_HALVES*CLK_DIV) ? 2*CLK_DIV : GAP_HALVES*CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_half_end = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_bit_end  = CNT_W'(2*CLK_DIV - 1);
    // The LOAD/IDLE cycle that follows supplies the final idle cycle of the gap.
    localparam logic [CNT_W-1:0] c_gap_end  = CNT_W'(GAP_HALVES*CLK_DIV - 2);
    localparam logic [3:0]       c_last_bit = 4'(PS2_FRAME_BITS - 1);

    logic [ENTRY_W-1:0]        w_entry;
    logic [ENTRY_W-1:0]        w_head;
    logic                      w_fifo_ready;
    logic                      w_fifo_valid;
    logic                      w_pop;
    logic                      w_more;
    logic [7:0]                w_load_byte;
    logic [PS2_FRAME_BITS-1:0] w_frame;

    ps2_state_t                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [3:0]                r_bit;
    logic [PS2_FRAME_BITS-2:0] r_frame;
    logic                      r_ps2_clk;
    logic                      r_ps2_data;
    logic                      r_overflow;

`ifdef PS2_TX_BREAK_EN
    logic       r_brk_pend;
    logic [7:0] r_held;

    assign w_entry     = {brk, data};
    assign w_pop       = (r_state == ST_LOAD) && !r_brk_pend;
    assign w_more      = w_fifo_valid || r_brk_pend;
    assign w_load_byte = r_brk_pend ? r_held : (w_head[8] ? PS2_BREAK_CODE : w_head[7:0]);

    // A break entry is popped once; its data byte is held for the second frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brk_pend <= 1'b0;
            r_held     <= '0;
        end else if (r_state == ST_LOAD) begin
            if (r_brk_pend) begin
                r_brk_pend <= 1'b0;
            end else if (w_head[8]) begin
                r_brk_pend <= 1'b1;
                r_held     <= w_head[7:0];
            end
        end
    end
`else
    assign w_entry     = data;
    assign w_pop       = (r_state == ST_LOAD);
    assign w_more      = w_fifo_valid;
    assign w_load_byte = w_head;
`endif

    assign w_frame = ps2_build_frame(w_load_byte);

    ps2_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid),
        .in_data   (w_entry),
        .in_ready  (w_fifo_ready),
        .out_valid (w_fifo_valid),
        .out_data  (w_head),
        .out_ready (w_pop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_frame    <= '0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_more) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_ps2_data <= w_frame[0];
                    r_frame    <= w_frame[PS2_FRAME_BITS-1:1];
                    r_ps2_clk  <= 1'b1;
                    r_cnt      <= '0;
                    r_bit      <= '0;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_cnt == c_bit_end) begin
                        r_cnt     <= '0;
                        r_ps2_clk <= 1'b1;
                        if (r_bit == c_last_bit) begin
                            r_ps2_data <= 1'b1;
                            r_state    <= ST_GAP;
                        end else begin
                            r_ps2_data <= r_frame[0];
                            r_frame    <= {1'b1, r_frame[PS2_FRAME_BITS-2:1]};
                            r_bit      <= r_bit + 4'd1;
                        end
                    end else begin
                        if (r_cnt == c_half_end) r_ps2_clk <= 1'b0;
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_end) begin
                        r_cnt   <= '0;
                        r_state <= w_more ? ST_LOAD : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_overflow <= 1'b0;
        else if (valid && !w_fifo_ready) r_overflow <= 1'b1;
    end

    assign ready    = w_fifo_ready;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign busy     = (r_state != ST_IDLE) || w_fifo_valid;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
